// File: rtl/multi_alarm_ctrl_pkg.sv
// Shared constants and types for the multi-channel alarm controller.
//   HOURS_PER_DAY / MIN_PER_HOUR / SEC_PER_MIN : clock field ranges
//   alarm_state_e                              : ring arbitration FSM encoding
//   idx_width()                                : channel index width, at least 1 bit
package multi_alarm_ctrl_pkg;

    localparam int unsigned HOURS_PER_DAY = 24;
    localparam int unsigned MIN_PER_HOUR  = 60;
    localparam int unsigned SEC_PER_MIN   = 60;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RINGING = 1'b1
    } alarm_state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multi_alarm_ctrl_if.sv
// Bus bundle between the clock top (master) and the alarm controller (slave).
//   master drives : sec_tick, cur_hour/minute/second, dnd, wr_* write port,
//                   stop_req, snooze_req
//   slave drives  : ring, ring_id, en_mask, pend_mask, wr_err
interface multi_alarm_ctrl_if #(
    parameter int unsigned N_ALARM = 4,
    parameter int unsigned TW      = 11
) ();
    import multi_alarm_ctrl_pkg::*;

    localparam int unsigned IW = idx_width(N_ALARM);

    logic               sec_tick;
    logic [TW-1:0]      cur_hour;
    logic [TW-1:0]      cur_minute;
    logic [TW-1:0]      cur_second;
    logic               dnd;
    logic               wr_en;
    logic [IW-1:0]      wr_sel;
    logic [TW-1:0]      wr_hour;
    logic [TW-1:0]      wr_minute;
    logic [TW-1:0]      wr_second;
    logic               wr_enable;
    logic               stop_req;
    logic               snooze_req;
    logic               ring;
    logic [IW-1:0]      ring_id;
    logic [N_ALARM-1:0] en_mask;
    logic [N_ALARM-1:0] pend_mask;
    logic               wr_err;

    modport master (
        output sec_tick, cur_hour, cur_minute, cur_second, dnd,
               wr_en, wr_sel, wr_hour, wr_minute, wr_second, wr_enable,
               stop_req, snooze_req,
        input  ring, ring_id, en_mask, pend_mask, wr_err
    );

    modport slave (
        input  sec_tick, cur_hour, cur_minute, cur_second, dnd,
               wr_en, wr_sel, wr_hour, wr_minute, wr_second, wr_enable,
               stop_req, snooze_req,
        output ring, ring_id, en_mask, pend_mask, wr_err
    );

endinterface

// File: rtl/multi_alarm_ctrl_time_add.sv
// Combinational hh:mm + OFFSET_MIN minutes with hour carry and midnight wrap.
//   hour_i, minute_i   : base time (hour 0..23, minute 0..59)
//   hour_o, minute_o   : shifted time
module multi_alarm_ctrl_time_add
    import multi_alarm_ctrl_pkg::*;
#(
    parameter int unsigned TW         = 11,
    parameter int unsigned OFFSET_MIN = 5
) (
    input  logic [TW-1:0] hour_i,
    input  logic [TW-1:0] minute_i,
    output logic [TW-1:0] hour_o,
    output logic [TW-1:0] minute_o
);

    localparam int unsigned SW = TW + 1;

    logic [SW-1:0] min_raw;
    logic [SW-1:0] hour_inc;
    logic          carry;

    // Offset is below one hour, so a single conditional subtract suffices.
    always_comb begin
        min_raw  = {1'b0, minute_i} + SW'(OFFSET_MIN);
        carry    = (min_raw >= SW'(MIN_PER_HOUR));
        minute_o = carry ? TW'(min_raw - SW'(MIN_PER_HOUR)) : TW'(min_raw);
        hour_inc = {1'b0, hour_i} + SW'(carry);
        hour_o   = (hour_inc >= SW'(HOURS_PER_DAY)) ? '0 : TW'(hour_inc);
    end

endmodule

// File: rtl/multi_alarm_ctrl.sv
// N-channel alarm controller: stores alarm times, matches them against the
// current time on each sec_tick, arbitrates ringing with pending queueing,
// snooze slots and ring auto-timeout.
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : slave side of multi_alarm_ctrl_if (time, write port, buttons
//               in; ring, ring_id, en_mask, pend_mask, wr_err out)
module multi_alarm_ctrl
    import multi_alarm_ctrl_pkg::*;
#(
    parameter int unsigned N_ALARM    = 4,
    parameter int unsigned TW         = 11,
    parameter int unsigned SNOOZE_MIN = 5,
    parameter int unsigned RING_SEC   = 60
) (
    input  logic                clk,
    input  logic                rst,
    multi_alarm_ctrl_if.slave   bus
);

    localparam int unsigned IW = idx_width(N_ALARM);
    localparam int unsigned CW = 8;

    logic [TW-1:0]      al_hour_q  [N_ALARM];
    logic [TW-1:0]      al_min_q   [N_ALARM];
    logic [TW-1:0]      al_sec_q   [N_ALARM];
    logic [TW-1:0]      snz_hour_q [N_ALARM];
    logic [TW-1:0]      snz_min_q  [N_ALARM];
    logic [TW-1:0]      snz_sec_q  [N_ALARM];

    logic [N_ALARM-1:0] en_q, pend_q, pend_d, snz_vld_q, snz_vld_d;
    alarm_state_e       state_q, state_d;
    logic [IW-1:0]      ring_id_q, ring_id_d;
    logic               ring_q, ring_d;
    logic [CW-1:0]      ring_cnt_q, ring_cnt_d;
    logic               wr_err_q, wr_err_d;

    logic               wr_ok_c;
    logic [N_ALARM-1:0] wr_oh_c, hit_c, snz_match_c, cand_c, snz_set_c, ring_oh_c;
    logic               cand_any_c;
    logic [IW-1:0]      cand_idx_c;
    logic [TW-1:0]      snz_hour_c, snz_min_c;

    // Snooze target: current hh:mm plus the snooze offset.
    multi_alarm_ctrl_time_add #(
        .TW         (TW),
        .OFFSET_MIN (SNOOZE_MIN)
    ) u_snooze_add (
        .hour_i   (bus.cur_hour),
        .minute_i (bus.cur_minute),
        .hour_o   (snz_hour_c),
        .minute_o (snz_min_c)
    );

    // Write validation and one-hot channel select.
    always_comb begin
        wr_ok_c = bus.wr_en
                  && (bus.wr_hour   < TW'(HOURS_PER_DAY))
                  && (bus.wr_minute < TW'(MIN_PER_HOUR))
                  && (bus.wr_second < TW'(SEC_PER_MIN))
                  && (32'(bus.wr_sel) < N_ALARM);
        for (int unsigned i = 0; i < N_ALARM; i++) begin
            wr_oh_c[i]   = wr_ok_c && (32'(bus.wr_sel) == i);
            ring_oh_c[i] = (32'(ring_id_q) == i);
        end
    end

    // Per-channel match; a snooze slot is consumed when its time comes, even under dnd.
    always_comb begin
        for (int unsigned i = 0; i < N_ALARM; i++) begin
            snz_match_c[i] = bus.sec_tick && snz_vld_q[i]
                             && (bus.cur_hour   == snz_hour_q[i])
                             && (bus.cur_minute == snz_min_q[i])
                             && (bus.cur_second == snz_sec_q[i]);
            hit_c[i] = bus.sec_tick && !bus.dnd
                       && ((en_q[i] && (bus.cur_hour   == al_hour_q[i])
                                    && (bus.cur_minute == al_min_q[i])
                                    && (bus.cur_second == al_sec_q[i]))
                           || snz_match_c[i]);
        end
    end

    // Lowest-index ring candidate; a channel being rewritten is not eligible.
    always_comb begin
        cand_c     = (hit_c | pend_q) & ~wr_oh_c & {N_ALARM{!bus.dnd}};
        cand_any_c = 1'b0;
        cand_idx_c = '0;
        for (int i = int'(N_ALARM) - 1; i >= 0; i--) begin
            if (cand_c[i]) begin
                cand_any_c = 1'b1;
                cand_idx_c = IW'(i);
            end
        end
    end

    // Ring arbitration FSM: next state and registered-output next values.
    always_comb begin
        state_d    = state_q;
        ring_id_d  = ring_id_q;
        ring_cnt_d = ring_cnt_q;
        pend_d     = pend_q;
        snz_set_c  = '0;

        case (state_q)
            ST_IDLE: begin
                pend_d = pend_q | hit_c;
                if (cand_any_c) begin
                    state_d            = ST_RINGING;
                    ring_id_d          = cand_idx_c;
                    ring_cnt_d         = CW'(RING_SEC);
                    pend_d[cand_idx_c] = 1'b0;
                end
            end
            ST_RINGING: begin
                pend_d = pend_q | (hit_c & ~ring_oh_c);
                if (bus.dnd || bus.stop_req) begin
                    state_d = ST_IDLE;
                end else if (bus.snooze_req) begin
                    state_d   = ST_IDLE;
                    snz_set_c = ring_oh_c;
                end else if (|(wr_oh_c & ring_oh_c)) begin
                    state_d = ST_IDLE;
                end else if (bus.sec_tick) begin
                    ring_cnt_d = ring_cnt_q - CW'(1);
                    if (ring_cnt_q == CW'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        pend_d    = pend_d & ~wr_oh_c;
        if (bus.dnd) begin
            pend_d = '0;
        end
        snz_vld_d = ((snz_vld_q & ~snz_match_c) | snz_set_c) & ~wr_oh_c;
        if (state_d == ST_IDLE) begin
            ring_id_d = '0;
        end
        ring_d   = (state_d == ST_RINGING);
        wr_err_d = bus.wr_en && !wr_ok_c;
    end

    // FSM and control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ring_id_q  <= '0;
            ring_cnt_q <= '0;
            ring_q     <= 1'b0;
            pend_q     <= '0;
            snz_vld_q  <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ring_id_q  <= ring_id_d;
            ring_cnt_q <= ring_cnt_d;
            ring_q     <= ring_d;
            pend_q     <= pend_d;
            snz_vld_q  <= snz_vld_d;
            wr_err_q   <= wr_err_d;
        end
    end

    // Per-channel alarm and snooze time storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q <= '0;
            for (int unsigned i = 0; i < N_ALARM; i++) begin
                al_hour_q[i]  <= '0;
                al_min_q[i]   <= '0;
                al_sec_q[i]   <= '0;
                snz_hour_q[i] <= '0;
                snz_min_q[i]  <= '0;
                snz_sec_q[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_ALARM; i++) begin
                if (wr_oh_c[i]) begin
                    al_hour_q[i] <= bus.wr_hour;
                    al_min_q[i]  <= bus.wr_minute;
                    al_sec_q[i]  <= bus.wr_second;
                    en_q[i]      <= bus.wr_enable;
                end
                if (snz_set_c[i]) begin
                    snz_hour_q[i] <= snz_hour_c;
                    snz_min_q[i]  <= snz_min_c;
                    snz_sec_q[i]  <= bus.cur_second;
                end
            end
        end
    end

    assign bus.ring      = ring_q;
    assign bus.ring_id   = ring_id_q;
    assign bus.en_mask   = en_q;
    assign bus.pend_mask = pend_q;
    assign bus.wr_err    = wr_err_q;

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// Self-checking bench for multi_alarm_ctrl: directed scenarios followed by
// randomized traffic, all compared against a seconds-of-day reference model.
module tb_multi_alarm_ctrl;

    localparam int N      = 4;
    localparam int SNOOZE = 5;
    localparam int RSEC   = 60;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multi_alarm_ctrl_if #(.N_ALARM(N), .TW(11)) bus ();

    multi_alarm_ctrl #(
        .N_ALARM    (N),
        .TW         (11),
        .SNOOZE_MIN (SNOOZE),
        .RING_SEC   (RSEC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: times kept as seconds of day.
    int m_alarm [N];
    bit m_en    [N];
    bit m_pend  [N];
    bit m_sv    [N];
    int m_snz   [N];
    bit m_ring;
    int m_ch;
    int m_left;
    bit m_werr;

    int pool [8] = '{6*3600, 6*3600+5*60, 7*3600+30*60, 7*3600+35*60,
                     23*3600+58*60+10, 3*60+10, 86399, 4*60+59};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] pack(input bit v [N]);
        logic [3:0] r;
        for (int i = 0; i < N; i++) r[i] = v[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_alarm[i] = 0; m_en[i] = 0; m_pend[i] = 0; m_sv[i] = 0; m_snz[i] = 0;
        end
        m_ring = 0; m_ch = 0; m_left = 0; m_werr = 0;
    endtask

    // Advance the model by one clock using the inputs currently on the bus.
    task automatic model_step();
        int cur, wsel, first, snz_ch;
        bit wok, tick, dnd;
        bit hit [N];
        bit smatch [N];
        cur  = int'(bus.cur_hour) * 3600 + int'(bus.cur_minute) * 60 + int'(bus.cur_second);
        tick = bus.sec_tick;
        dnd  = bus.dnd;
        wsel = int'(bus.wr_sel);
        wok  = bus.wr_en && bus.wr_hour < 24 && bus.wr_minute < 60 && bus.wr_second < 60 && wsel < N;
        for (int i = 0; i < N; i++) begin
            smatch[i] = tick && m_sv[i] && (m_snz[i] == cur);
            hit[i]    = tick && !dnd && ((m_en[i] && m_alarm[i] == cur) || smatch[i]);
        end
        snz_ch = -1;
        if (m_ring) begin
            for (int i = 0; i < N; i++) if (hit[i] && i != m_ch) m_pend[i] = 1;
            if (dnd || bus.stop_req) m_ring = 0;
            else if (bus.snooze_req) begin m_ring = 0; snz_ch = m_ch; end
            else if (wok && wsel == m_ch) m_ring = 0;
            else if (tick) begin
                m_left--;
                if (m_left == 0) m_ring = 0;
            end
        end else begin
            first = -1;
            for (int i = 0; i < N; i++) if (hit[i]) m_pend[i] = 1;
            for (int i = 0; i < N; i++)
                if (first < 0 && !dnd && m_pend[i] && !(wok && wsel == i)) first = i;
            if (first >= 0) begin
                m_ring = 1; m_ch = first; m_left = RSEC; m_pend[first] = 0;
            end
        end
        for (int i = 0; i < N; i++) if (smatch[i]) m_sv[i] = 0;
        if (snz_ch >= 0) begin
            m_sv[snz_ch]  = 1;
            m_snz[snz_ch] = ((cur / 60 + SNOOZE) % 1440) * 60 + cur % 60;
        end
        if (wok) begin
            m_alarm[wsel] = int'(bus.wr_hour) * 3600 + int'(bus.wr_minute) * 60 + int'(bus.wr_second);
            m_en[wsel] = bus.wr_enable; m_pend[wsel] = 0; m_sv[wsel] = 0;
        end
        if (dnd) for (int i = 0; i < N; i++) m_pend[i] = 0;
        m_werr = bus.wr_en && !wok;
    endtask

    task automatic compare_all();
        chk("ring",      32'(bus.ring),      32'(m_ring));
        chk("ring_id",   32'(bus.ring_id),   m_ring ? 32'(m_ch) : 32'd0);
        chk("en_mask",   32'(bus.en_mask),   32'(pack(m_en)));
        chk("pend_mask", 32'(bus.pend_mask), 32'(pack(m_pend)));
        chk("wr_err",    32'(bus.wr_err),    32'(m_werr));
    endtask

    task automatic clear_pulses();
        bus.sec_tick = 0; bus.wr_en = 0; bus.stop_req = 0; bus.snooze_req = 0;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
        clear_pulses();
    endtask

    task automatic set_cur(input int t);
        bus.cur_hour = 11'(t / 3600); bus.cur_minute = 11'((t / 60) % 60); bus.cur_second = 11'(t % 60);
    endtask

    task automatic do_write(input int ch, input int h, input int m, input int s, input bit en);
        bus.wr_en = 1; bus.wr_sel = 2'(ch); bus.wr_enable = en;
        bus.wr_hour = 11'(h); bus.wr_minute = 11'(m); bus.wr_second = 11'(s);
        cyc();
    endtask

    task automatic do_tick(input int t);
        set_cur(t); bus.sec_tick = 1; cyc();
    endtask

    task automatic do_stop();   bus.stop_req = 1;   cyc(); endtask
    task automatic do_snooze(); bus.snooze_req = 1; cyc(); endtask

    task automatic random_cycle();
        int r, t, ch;
        r = int'($urandom_range(0, 99));
        if ($urandom_range(0, 59) == 0) bus.dnd = ~bus.dnd;
        t  = pool[$urandom_range(0, 7)];
        ch = int'($urandom_range(0, N - 1));
        if ($urandom_range(0, 3) == 0 && m_sv[ch]) t = m_snz[ch];
        set_cur(t);
        if (r < 8) begin
            t = pool[$urandom_range(0, 7)];
            bus.wr_en = 1; bus.wr_sel = 2'($urandom_range(0, N - 1));
            bus.wr_enable = ($urandom_range(0, 4) != 0);
            bus.wr_hour = 11'(t / 3600); bus.wr_minute = 11'((t / 60) % 60); bus.wr_second = 11'(t % 60);
            case ($urandom_range(0, 9))
                0: bus.wr_hour   = 11'(24 + $urandom_range(0, 9));
                1: bus.wr_minute = 11'(60 + $urandom_range(0, 9));
                2: bus.wr_second = 11'(60 + $urandom_range(0, 9));
                default: ;
            endcase
        end else begin
            bus.sec_tick   = ($urandom_range(0, 2) == 0);
            bus.stop_req   = ($urandom_range(0, 24) == 0);
            bus.snooze_req = ($urandom_range(0, 24) == 0);
        end
        cyc();
    endtask

    initial begin
        clear_pulses();
        bus.dnd = 0; bus.wr_sel = '0; bus.wr_enable = 0;
        bus.wr_hour = '0; bus.wr_minute = '0; bus.wr_second = '0;
        set_cur(0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        rst = 0;

        // Single channel match and ring
        do_write(2, 7, 30, 0, 1);
        do_tick(7*3600 + 30*60);
        chk("t1_ring", 32'(bus.ring), 32'd1);
        chk("t1_ring_id", 32'(bus.ring_id), 32'd2);

        // Auto-stop after RING_SEC ticks
        for (int k = 1; k < RSEC; k++) do_tick(7*3600 + 30*60 + k);
        chk("t2_ring_before", 32'(bus.ring), 32'd1);
        do_tick(7*3600 + 31*60);
        chk("t2_ring_after", 32'(bus.ring), 32'd0);
        chk("t2_en2", 32'(bus.en_mask[2]), 32'd1);

        // Snooze across midnight
        do_write(0, 23, 58, 10, 1);
        do_tick(23*3600 + 58*60 + 10);
        chk("t3_ring_id", 32'(bus.ring_id), 32'd0);
        do_snooze();
        chk("t3_snoozed", 32'(bus.ring), 32'd0);
        do_tick(3*60 + 10);
        chk("t3_reRing", 32'(bus.ring), 32'd1);
        chk("t3_reRing_id", 32'(bus.ring_id), 32'd0);
        do_stop();

        // Two channels same time: lowest first, other pending
        do_write(1, 6, 0, 0, 1);
        do_write(3, 6, 0, 0, 1);
        do_tick(6*3600);
        chk("t4_ring_id", 32'(bus.ring_id), 32'd1);
        chk("t4_pend", 32'(bus.pend_mask), 32'h8);
        do_stop();
        chk("t4_stopped", 32'(bus.ring), 32'd0);
        cyc();
        chk("t4_next_ring", 32'(bus.ring), 32'd1);
        chk("t4_next_id", 32'(bus.ring_id), 32'd3);
        do_stop();
        cyc();

        // Do-not-disturb
        bus.dnd = 1;
        do_tick(6*3600);
        chk("t5_dnd_quiet", 32'(bus.ring), 32'd0);
        bus.dnd = 0;
        do_tick(6*3600);
        chk("t5_ring", 32'(bus.ring), 32'd1);
        bus.dnd = 1;
        cyc();
        chk("t5_dnd_ring", 32'(bus.ring), 32'd0);
        chk("t5_dnd_pend", 32'(bus.pend_mask), 32'd0);
        bus.dnd = 0;
        cyc();

        // Rejected write, then reset mid-ring
        do_write(1, 24, 0, 0, 0);
        chk("t6_wr_err", 32'(bus.wr_err), 32'd1);
        chk("t6_en_kept", 32'(bus.en_mask), 32'hF);
        cyc();
        chk("t6_wr_err_pulse", 32'(bus.wr_err), 32'd0);
        do_tick(6*3600);
        chk("t6_ch1_kept", 32'(bus.ring_id), 32'd1);
        rst = 1;
        #1;
        model_reset();
        compare_all();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;

        // Randomized traffic
        for (int k = 0; k < 3000; k++) random_cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
